// File: rtl/iomem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : iomem_arbiter
//  Description : Two-master round-robin arbiter for a picosoc-style native
//                memory port (valid/ready). One transaction per grant, with a
//                bus timeout that aborts a stalled transfer and returns
//                ERR_DATA so a dead slave cannot hang the CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module iomem_arbiter #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = {DATA_W{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_valid,
  output logic                  m0_ready,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  input  logic [DATA_W/8-1:0]   m0_wstrb,
  output logic [DATA_W-1:0]     m0_rdata,

  input  logic                  m1_valid,
  output logic                  m1_ready,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  output logic [DATA_W-1:0]     m1_rdata,

  output logic                  s_valid,
  input  logic                  s_ready,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  input  logic [DATA_W-1:0]     s_rdata,

  output logic [1:0]            grant,
  output logic                  timeout
);

  // Stall counter only needs to reach TIMEOUT; keep one bit when disabled.
  localparam int                c_cnt_w   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);
  localparam bit                c_to_en   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t             r_state;
  logic [1:0]         r_grant;
  logic               r_last_m1;   // 1 when m1 was the most recent owner
  logic [c_cnt_w-1:0] r_cnt;

  logic w_own0;
  logic w_own1;
  logic w_own_valid;
  logic w_timeout;

  // Ownership is taken from the registered grant; reset drops it at once so
  // no ready can escape during the reset cycle.
  assign w_own0      = r_grant[0] & ~rst;
  assign w_own1      = r_grant[1] & ~rst;
  assign w_own_valid = (w_own0 & m0_valid) | (w_own1 & m1_valid);

  // Abort when the stall count has reached the limit; a slave ready arriving
  // on that same cycle still completes normally.
  assign w_timeout   = c_to_en & w_own_valid & ~s_ready & (r_cnt == c_timeout);

  assign grant       = r_grant;
  assign timeout     = w_timeout;

  // Slave-side request mux and master-side ready/rdata return.
  always_comb begin
    s_valid  = w_own_valid & ~w_timeout;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    if (w_own0) begin
      s_addr   = m0_addr;
      s_wdata  = m0_wdata;
      s_wstrb  = m0_wstrb;
      m0_ready = m0_valid & (s_ready | w_timeout);
      m0_rdata = w_timeout ? ERR_DATA : s_rdata;
    end else if (w_own1) begin
      s_addr   = m1_addr;
      s_wdata  = m1_wdata;
      s_wstrb  = m1_wstrb;
      m1_ready = m1_valid & (s_ready | w_timeout);
      m1_rdata = w_timeout ? ERR_DATA : s_rdata;
    end
  end

  // Arbitration FSM: pick an owner from IDLE, hold it for one transaction,
  // then always pass back through IDLE so a waiting peer gets its turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= 2'b00;
      r_last_m1 <= 1'b1;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (m0_valid && (!m1_valid || r_last_m1)) begin
            r_state   <= ST_OWN0;
            r_grant   <= 2'b01;
            r_last_m1 <= 1'b0;
          end else if (m1_valid) begin
            r_state   <= ST_OWN1;
            r_grant   <= 2'b10;
            r_last_m1 <= 1'b1;
          end
        end
        ST_OWN0, ST_OWN1: begin
          // Completion, abort, or the owner withdrawing its request all end
          // the tenure.
          if (!w_own_valid || s_ready || w_timeout) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_cnt   <= '0;
          end else if (r_cnt != c_timeout) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 2'b00;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
